// File: rtl/numpy_to_polyphony_polyphony_lib_complex_mac.sv
// Pipelined fixed-point complex multiply-accumulate with valid/ready flow control.
// Three register stages: operand capture, full-precision products, accumulate/round/saturate.
module numpy_to_polyphony_polyphony_lib_complex_mac #(
  parameter int BIT        = 32,
  parameter int PRECISION  = 16,
  parameter int ACC_GUARD  = 8,
  parameter int ROUND      = 0,
  parameter int ACCUMULATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*BIT-1:0] in_a,
  input  logic [2*BIT-1:0] in_b,
  input  logic             in_conj,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*BIT-1:0] out_data,
  output logic             out_sat
);

  localparam int PW = 2 * BIT + 2;
  localparam int AW = PW + ACC_GUARD;
  localparam int RW = AW + 1;

  localparam logic signed [RW-1:0] SAT_MAX   = {{(RW-BIT+1){1'b0}}, {(BIT-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN   = {{(RW-BIT+1){1'b1}}, {(BIT-1){1'b0}}};
  localparam logic signed [RW-1:0] HALF      = RW'(1) << (PRECISION - 1);
  localparam logic signed [RW-1:0] ROUND_ADD = (ROUND != 0) ? HALF : '0;

  logic en;
  logic out_valid_reg;
  logic [2*BIT-1:0] out_data_reg;
  logic out_sat_reg;

  assign en        = !out_valid_reg || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;

  // Stage 1: operand capture; conjugation widens b_imag so -(-2^(BIT-1)) stays exact.
  logic                  s1_valid_reg, s1_last_reg;
  logic signed [BIT-1:0] s1_ar_reg, s1_ai_reg, s1_br_reg;
  logic signed [BIT:0]   s1_bi_reg;
  logic signed [BIT:0]   bi_next;

  always_comb begin
    bi_next = {in_b[BIT-1], in_b[BIT-1:0]};
    if (in_conj) begin
      bi_next = -bi_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_ar_reg    <= '0;
      s1_ai_reg    <= '0;
      s1_br_reg    <= '0;
      s1_bi_reg    <= '0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      s1_last_reg  <= in_last || (ACCUMULATE == 0);
      s1_ar_reg    <= in_a[2*BIT-1:BIT];
      s1_ai_reg    <= in_a[BIT-1:0];
      s1_br_reg    <= in_b[2*BIT-1:BIT];
      s1_bi_reg    <= bi_next;
    end
  end

  // Stage 2: full-precision products and complex combination.
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] re_next, im_next;

  always_comb begin
    ar_x    = PW'(s1_ar_reg);
    ai_x    = PW'(s1_ai_reg);
    br_x    = PW'(s1_br_reg);
    bi_x    = PW'(s1_bi_reg);
    re_next = ar_x * br_x - ai_x * bi_x;
    im_next = ar_x * bi_x + ai_x * br_x;
  end

  logic                 s2_valid_reg, s2_last_reg;
  logic signed [PW-1:0] s2_part_reg [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg   <= 1'b0;
      s2_last_reg    <= 1'b0;
      s2_part_reg[0] <= '0;
      s2_part_reg[1] <= '0;
    end else if (en) begin
      s2_valid_reg   <= s1_valid_reg;
      s2_last_reg    <= s1_last_reg;
      s2_part_reg[1] <= re_next;
      s2_part_reg[0] <= im_next;
    end
  end

  // Stage 3: per-component accumulator and result formatting; gi=1 is real, gi=0 is imaginary.
  logic [2*BIT-1:0] data_next;
  logic [1:0]       sat_next;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_part
      logic signed [AW-1:0] acc_reg;
      logic signed [AW-1:0] sum;
      logic signed [RW-1:0] rnd, shr;
      logic [BIT-1:0]       val;
      logic                 sat;

      always_comb begin
        sum = acc_reg + AW'(s2_part_reg[gi]);
        rnd = RW'(sum) + ROUND_ADD;
        shr = rnd >>> PRECISION;
        val = shr[BIT-1:0];
        sat = 1'b0;
        if (shr > SAT_MAX) begin
          val = SAT_MAX[BIT-1:0];
          sat = 1'b1;
        end else if (shr < SAT_MIN) begin
          val = SAT_MIN[BIT-1:0];
          sat = 1'b1;
        end
      end

      assign data_next[gi*BIT +: BIT] = val;
      assign sat_next[gi]             = sat;

      // Wraps silently on overlong packets; cleared whenever a result is produced.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg <= '0;
        end else if (en && s2_valid_reg) begin
          acc_reg <= s2_last_reg ? '0 : sum;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (en) begin
      out_valid_reg <= s2_valid_reg && s2_last_reg;
      if (s2_valid_reg && s2_last_reg) begin
        out_data_reg <= data_next;
        out_sat_reg  <= |sat_next;
      end
    end
  end

endmodule

// File: tb/tb_numpy_to_polyphony_polyphony_lib_complex_mac.sv
// Scoreboard bench: a truncating and a rounding instance share stimulus; each has its own
// expected-result queue drained by an independent monitor.
module tb_numpy_to_polyphony_polyphony_lib_complex_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_conj = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [63:0] out_data0, out_data1;
  logic        out_sat0, out_sat1;

  typedef struct {
    logic [63:0] data;
    logic        sat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  numpy_to_polyphony_polyphony_lib_complex_mac #(
    .BIT(32), .PRECISION(16), .ACC_GUARD(8), .ROUND(0), .ACCUMULATE(1)
  ) dut_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_conj(in_conj), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
  );

  numpy_to_polyphony_polyphony_lib_complex_mac #(
    .BIT(32), .PRECISION(16), .ACC_GUARD(8), .ROUND(1), .ACCUMULATE(1)
  ) dut_round (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_conj(in_conj), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%016h (t=%0t)", name, act, $time);
    end
  endtask

  // Monitors sample at negedge; out_ready only changes 2ns after a posedge, so the pair is stable.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_trunc: got 0x%016h, expected no result", out_data0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("trunc_data", out_data0, e.data);
        check("trunc_sat", {63'd0, out_sat0}, {63'd0, e.sat});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_round: got 0x%016h, expected no result", out_data1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("round_data", out_data1, e.data);
        check("round_sat", {63'd0, out_sat1}, {63'd0, e.sat});
      end
    end
  end

  // Drive one beat, wait (bounded) for acceptance, and push expectations when push=1.
  task automatic send(input logic [31:0] ar, input logic [31:0] ai,
                      input logic [31:0] br, input logic [31:0] bi,
                      input logic conj, input logic last, input logic push,
                      input logic [63:0] e0, input logic [63:0] e1, input logic es);
    int t;
    @(negedge clk);
    in_a = {ar, ai};
    in_b = {br, bi};
    in_conj = conj;
    in_last = last;
    in_valid = 1'b1;
    #1;
    t = 0;
    while (!in_ready0 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready0) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    if (push) begin
      q0.push_back('{data: e0, sat: es});
      q1.push_back('{data: e1, sat: es});
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) begin
      @(posedge clk);
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", q0.size(), q1.size());
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", {63'd0, out_valid0}, 64'd0);
    check("reset_out_data", out_data0, 64'd0);
    check("reset_out_sat", {63'd0, out_sat0}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready0}, 64'd1);

    // 1: (1+2i)(3-i) = 5+5i, then latency of the result
    e = {32'h0005_0000, 32'h0005_0000};
    send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'hFFFF_0000, 1'b0, 1'b1, 1'b1, e, e, 1'b0);
    check("latency_after_N", {63'd0, out_valid0}, 64'd0);
    @(posedge clk); #1;
    check("latency_after_N1", {63'd0, out_valid0}, 64'd0);
    @(posedge clk); #1;
    check("latency_after_N2", {63'd0, out_valid0}, 64'd1);
    wait_idle();

    // 2: conjugate, including b_imag = -2^31 negated to +2^31
    send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 1'b1, 1'b1, 1'b1, e, e, 1'b0);
    e = {32'h0000_0000, 32'h0080_0000};
    send(32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, e, e, 1'b0);
    wait_idle();

    // 3: four beats of 0.5+0.5i, then a back-to-back three-beat packet of 1+1i
    e = {32'h0002_0000, 32'h0002_0000};
    for (int i = 0; i < 4; i++) begin
      send(32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0000_8000, 1'b0, (i == 3), (i == 3), e, e, 1'b0);
    end
    e = {32'h0003_0000, 32'h0003_0000};
    for (int i = 0; i < 3; i++) begin
      send(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, (i == 2), (i == 2), e, e, 1'b0);
    end
    wait_idle();

    // 4: saturation high and low
    e = {32'h7FFF_FFFF, 32'h0000_0000};
    send(32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b1, e, e, 1'b1);
    e = {32'h8000_0000, 32'h0000_0000};
    send(32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b1, e, e, 1'b1);
    wait_idle();

    // 5: half-lsb rounding, positive and negative
    send(32'h0000_0001, 32'h0, 32'h0000_8000, 32'h0, 1'b0, 1'b1, 1'b1,
         64'h0000_0000_0000_0000, 64'h0000_0001_0000_0000, 1'b0);
    send(32'hFFFF_FFFF, 32'h0, 32'h0000_8000, 32'h0, 1'b0, 1'b1, 1'b1,
         64'hFFFF_FFFF_0000_0000, 64'h0000_0000_0000_0000, 1'b0);
    wait_idle();

    // 6a: eight single-beat packets k*(1+ki) with a 5-cycle output stall
    fork
      begin
        for (int k = 1; k <= 8; k++) begin
          logic [31:0] kk, re_e, im_e;
          kk = 32'(k) << 16;
          re_e = 32'(k) << 16;
          im_e = 32'(k * k) << 16;
          send(kk, 32'h0, 32'h0001_0000, kk, 1'b0, 1'b1, 1'b1, {re_e, im_e}, {re_e, im_e}, 1'b0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b0;
        @(posedge clk);
        #2;
        check("stall_in_ready", {63'd0, in_ready0}, 64'd0);
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    wait_idle();

    // 6b: reset mid-packet discards the open accumulation
    send(32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    send(32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid0}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready0}, 64'd1);
    e = {32'h0003_0000, 32'h0000_0000};
    send(32'h0001_0000, 32'h0, 32'h0003_0000, 32'h0, 1'b0, 1'b1, 1'b1, e, e, 1'b0);
    wait_idle();

    repeat (5) @(posedge clk);
    check("leftover_trunc", 64'(q0.size()), 64'd0);
    check("leftover_round", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
